dmem_portb_arbiter: RTL and testbench

Arbiter and sequencer for port B of the data memory in the RISC-V pipeline CPU. Port A stays owned by the MEM/WB stage. Port B is shared between two requesters:
- the debug host, which issues word/byte reads and writes through a req/gnt handshake;
- a built-in zero-fill engine, which sweeps the whole data memory writing 0 after a `clr_start` pulse.

The block drives the existing port-B debug pins (A2/WD2/WE2/RD2) and schedules the two requesters round-robin while a clear is running.

---
 rtl/dmem_portb_arbiter_if.sv | 20 ++
 rtl/dmem_portb_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_portb_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_portb_arbiter_if.sv
// Debug-host side of data-memory port B: request/grant access bus plus read return.
interface dmem_portb_arbiter_if;
  logic        dbg_req;
  logic [3:0]  dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata
  );
endinterface

// File: rtl/dmem_portb_arbiter.sv
// Port-B arbiter for the data memory: shares the port between the debug host and a
// zero-fill sweep, alternating owners round-robin while the clear is running.
module dmem_portb_arbiter #(
  parameter int unsigned DEPTH_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_portb_arbiter_if.slave   dbg,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [31:0]           A2,
  output logic [31:0]           WD2,
  output logic [3:0]            WE2,
  input  logic [31:0]           RD2
);

  localparam logic StIdle  = 1'b0;
  localparam logic StClear = 1'b1;

  localparam logic OwnDbg = 1'b0;
  localparam logic OwnClr = 1'b1;

  localparam logic [DEPTH_W-1:0] CntMax = '1;

  logic               state_q, state_d;
  logic [DEPTH_W-1:0] cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               done_q, done_d;
  logic               tag1_q, tag1_d;
  logic               tag2_q, tag2_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               dbg_acc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    done_d      = 1'b0;
    dbg_acc     = 1'b0;
    dbg.dbg_gnt = 1'b0;
    A2          = '0;
    WD2         = '0;
    WE2         = '0;

    // Port B stays quiet and ungranted while reset is held.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          dbg.dbg_gnt = 1'b1;
          if (dbg.dbg_req) begin
            dbg_acc = 1'b1;
            A2      = dbg.dbg_addr;
            WD2     = dbg.dbg_wdata;
            WE2     = dbg.dbg_we;
          end
          if (clr_start) begin
            state_d = StClear;
            cnt_d   = '0;
            owner_d = OwnDbg;
          end
        end
        StClear: begin
          dbg.dbg_gnt = (owner_q == OwnClr);
          if (dbg.dbg_req && dbg.dbg_gnt) begin
            dbg_acc = 1'b1;
            A2      = dbg.dbg_addr;
            WD2     = dbg.dbg_wdata;
            WE2     = dbg.dbg_we;
            owner_d = OwnDbg;
          end else begin
            // Unused debug slots fall through to the sweep.
            A2      = 32'({cnt_q, 2'b00});
            WE2     = 4'hF;
            owner_d = OwnClr;
            if (cnt_q == CntMax) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Two-stage read tag tracks the synchronous memory latency.
  always_comb begin
    tag1_d  = dbg_acc && (dbg.dbg_we == 4'h0);
    tag2_d  = tag1_q;
    rdata_d = tag1_q ? RD2 : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= OwnDbg;
      done_q  <= 1'b0;
      tag1_q  <= 1'b0;
      tag2_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      rdata_q <= rdata_d;
    end
  end

  assign clr_busy       = (state_q == StClear);
  assign clr_done       = done_q;
  assign dbg.dbg_rvalid = tag2_q;
  assign dbg.dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Bench for dmem_portb_arbiter with a 16-word memory; read results are scoreboarded.
module tb_dmem_portb_arbiter;
  localparam int unsigned DW = 4;
  localparam int unsigned NW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_start = 1'b0;
  logic        clr_busy, clr_done;
  logic [31:0] A2, WD2, RD2;
  logic [3:0]  WE2;

  dmem_portb_arbiter_if bus ();

  dmem_portb_arbiter #(.DEPTH_W(DW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .dbg       (bus.slave),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .A2        (A2),
    .WD2       (WD2),
    .WE2       (WE2),
    .RD2       (RD2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_seen = 0;
  int oob_cnt = 0;

  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];
  logic [31:0] exp_q[$];
  int          cyc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Synchronous memory model on port B.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (WE2[b]) mem[A2[DW+1:2]][8*b +: 8] <= WD2[8*b +: 8];
    RD2 <= mem[A2[DW+1:2]];
    if (WE2 != 4'h0 && A2 >= 32'h40) oob_cnt++;
  end

  always @(negedge clk) if (clr_done) done_seen++;

  always @(negedge clk) begin : rv_mon
    logic [31:0] d;
    int c;
    if (bus.dbg_rvalid) begin
      if (exp_q.size() == 0) begin
        check_eq("rvalid_unexp", 32'(bus.dbg_rvalid), 32'd0);
      end else begin
        d = exp_q.pop_front();
        c = cyc_q.pop_front();
        check_eq("rdata", bus.dbg_rdata, d);
        check_eq("rlat", 32'(cyc - c), 32'd2);
      end
    end
  end

  // Called at the negedge of a cycle in which req && gnt.
  task automatic note_accept();
    int idx = int'(bus.dbg_addr[DW+1:2]);
    check_eq("a2_pass", A2, bus.dbg_addr);
    check_eq("we2_pass", 32'(WE2), 32'(bus.dbg_we));
    check_eq("wd2_pass", WD2, bus.dbg_wdata);
    if (bus.dbg_we == 4'h0) begin
      exp_q.push_back(ref_mem[idx]);
      cyc_q.push_back(cyc);
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.dbg_we[b]) ref_mem[idx][8*b +: 8] = bus.dbg_wdata[8*b +: 8];
    end
  endtask

  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 1'b0;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.dbg_gnt) begin
        note_accept();
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check_eq("acc_timeout", 32'(got), 32'd1);
    bus.dbg_req = 1'b0;
    bus.dbg_we  = 4'h0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic zero_ref();
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_n, done_at, ndone, nacc;
    for (int i = 0; i < NW; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    // Drive a write during reset; port B must stay quiet.
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 4'hF;
    bus.dbg_addr  = 32'h10;
    bus.dbg_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", 32'(bus.dbg_gnt), 32'd0);
    check_eq("rst_we2", 32'(WE2), 32'd0);
    check_eq("rst_a2", A2, 32'd0);
    check_eq("rst_wd2", WD2, 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.dbg_req = 1'b0;
    bus.dbg_we  = 4'h0;
    @(negedge clk);
    check_eq("rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    check_eq("rst_rdata", bus.dbg_rdata, 32'd0);
    check_eq("rst_busy", 32'(clr_busy), 32'd0);
    check_eq("rst_done", 32'(clr_done), 32'd0);
    check_eq("idle_gnt", 32'(bus.dbg_gnt), 32'd1);
    @(posedge clk);
    #1;

    // Word write, read back, byte write, read back.
    access(4'hF, 32'h10, 32'hDEADBEEF);
    access(4'h0, 32'h10, 32'h0);
    drain();
    access(4'b0100, 32'h10, 32'h00AB0000);
    access(4'h0, 32'h10, 32'h0);
    drain();
    check_eq("byte_merge_ref", ref_mem[4], 32'hDEABBEEF);

    // Preload every word with a nonzero pattern.
    for (int i = 0; i < NW; i++) access(4'hF, 32'(i * 4), 32'h11110000 + 32'(i) + 32'd1);

    // Uncontended clear.
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    busy_n = 0;
    ndone = 0;
    done_at = -1;
    for (int rel = 1; rel <= 20; rel++) begin
      @(negedge clk);
      if (clr_busy) begin
        busy_n++;
        check_eq("clr_a2", A2, 32'((rel - 1) * 4));
        check_eq("clr_we2", 32'(WE2), 32'hF);
      end
      if (clr_done) begin
        ndone++;
        done_at = rel;
      end
      @(posedge clk);
      #1;
    end
    check_eq("clr_busy_len", 32'(busy_n), 32'd16);
    check_eq("clr_done_cnt", 32'(ndone), 32'd1);
    check_eq("clr_done_at", 32'(done_at), 32'd17);
    zero_ref();
    for (int i = 0; i < NW; i++) access(4'h0, 32'(i * 4), 32'h0);
    drain();

    // Clear with the debug host reading 0x3C every cycle.
    access(4'hF, 32'h3C, 32'h5A5A5A5A);
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 4'h0;
    bus.dbg_addr = 32'h3C;
    clr_start    = 1'b1;
    nacc = 0;
    done_at = -1;
    for (int rel = 0; rel <= 32; rel++) begin
      @(negedge clk);
      if (rel >= 1 && rel <= 31) begin
        check_eq("gnt_alt", 32'(bus.dbg_gnt), 32'(rel % 2 == 0));
        if (rel % 2 == 1) check_eq("cclr_a2", A2, 32'(((rel - 1) / 2) * 4));
      end
      if (rel == 32) zero_ref();
      if (bus.dbg_gnt) begin
        note_accept();
        nacc++;
      end
      if (clr_done) done_at = rel;
      @(posedge clk);
      #1;
      clr_start = 1'b0;
    end
    bus.dbg_req = 1'b0;
    check_eq("cclr_done_at", 32'(done_at), 32'd32);
    check_eq("cclr_reads", 32'(nacc), 32'd17);
    drain();

    // Back-to-back reads in consecutive cycles.
    access(4'hF, 32'h0, 32'hA0A00001);
    access(4'hF, 32'h4, 32'hA0A00002);
    access(4'hF, 32'h8, 32'hA0A00003);
    access(4'h0, 32'h0, 32'h0);
    access(4'h0, 32'h4, 32'h0);
    access(4'h0, 32'h8, 32'h0);
    drain();

    // Reset in the middle of a clear, with a read in flight.
    ndone = done_seen;
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    for (int rel = 1; rel <= 5; rel++) begin
      if (rel == 4) begin
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 4'h0;
        bus.dbg_addr = 32'h0;
      end
      if (rel == 5) begin
        bus.dbg_req = 1'b0;
        rst = 1'b1;
      end
      @(negedge clk);
      if (rel == 4) check_eq("mid_gnt", 32'(bus.dbg_gnt), 32'd1);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_busy", 32'(clr_busy), 32'd0);
    check_eq("mrst_done", 32'(clr_done), 32'd0);
    check_eq("mrst_gnt", 32'(bus.dbg_gnt), 32'd1);
    check_eq("mrst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("mrst_no_done", 32'(done_seen), 32'(ndone));

    // Restart must begin from word 0.
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    @(negedge clk);
    check_eq("rest_busy", 32'(clr_busy), 32'd1);
    check_eq("rest_a2", A2, 32'h0);
    check_eq("rest_we2", 32'(WE2), 32'hF);
    for (int i = 0; i < 40 && clr_busy; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("rest_end", 32'(clr_busy), 32'd0);
    zero_ref();
    @(posedge clk);
    #1;
    access(4'h0, 32'h0, 32'h0);
    access(4'h0, 32'h3C, 32'h0);
    drain();

    check_eq("oob_writes", 32'(oob_cnt), 32'd0);
    check_eq("done_total", 32'(done_seen), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
